// File: rtl/ram_bist_ctrl_pkg.sv
// Shared FSM encoding, error-counter sizing and test-pattern generator for the RAM BIST engine.
// Pure definitions: no clocked logic and no latency of its own.
package ram_bist_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_DRAIN,
      S_FIN
   } state_t;

   localparam int              ERR_W   = 8;
   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   // pass0 data = (addr + seed) mod 2**dw; pass1 data is its bitwise inverse.
   function automatic logic [31:0] pattern(input logic pass, input logic [31:0] addr,
                                           input int seed, input int dw);
      logic [31:0] mask;
      logic [31:0] v;
      mask = (dw >= 32) ? 32'hFFFF_FFFF : ((32'h1 << dw) - 32'h1);
      v    = (addr + 32'(seed)) & mask;
      if (pass)
         v = ~v & mask;
      return v;
   endfunction

endpackage

// File: rtl/ram_bist_chk.sv
// Read-data checker: RD_LAT-deep {valid,addr,expected} delay line aligned to RAM Q, then compare.
// Result registers update one clock after the tail is valid; no backpressure, clr wins over a compare.
module ram_bist_chk
   import ram_bist_ctrl_pkg::*;
#(
   parameter int AW     = 4,
   parameter int DW     = 4,
   parameter int RD_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             iss,
   input  logic [AW-1:0]    iss_addr,
   input  logic [DW-1:0]    iss_exp,
   input  logic [DW-1:0]    q,
   output logic             fail,
   output logic [AW-1:0]    fail_addr,
   output logic [ERR_W-1:0] err_cnt
);

   logic [RD_LAT-1:0] dl_vld;
   logic [AW-1:0]     dl_addr [RD_LAT];
   logic [DW-1:0]     dl_exp  [RD_LAT];
   logic              mismatch;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dl_vld <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            dl_addr[i] <= '0;
            dl_exp[i]  <= '0;
         end
      end else begin
         dl_vld[0]  <= iss;
         dl_addr[0] <= iss_addr;
         dl_exp[0]  <= iss_exp;
         for (int i = 1; i < RD_LAT; i++) begin
            dl_vld[i]  <= dl_vld[i-1];
            dl_addr[i] <= dl_addr[i-1];
            dl_exp[i]  <= dl_exp[i-1];
         end
      end
   end

   // Tail of the delay line lines up with the Q produced by that read.
   assign mismatch = dl_vld[RD_LAT-1] && (q != dl_exp[RD_LAT-1]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fail      <= 1'b0;
         fail_addr <= '0;
         err_cnt   <= '0;
      end else if (clr) begin
         fail      <= 1'b0;
         fail_addr <= '0;
         err_cnt   <= '0;
      end else if (mismatch) begin
         if (err_cnt != ERR_MAX)
            err_cnt <= err_cnt + 1'b1;
         if (!fail) begin
            fail      <= 1'b1;
            fail_addr <= dl_addr[RD_LAT-1];
         end
      end
   end

endmodule

// File: rtl/ram_bist_ctrl.sv
// RAM BIST initiator: writes/reads every address with a true then an inverted pattern and checks Q.
// RAM drive is registered, BUSY spans 2*(2**(AW+1)+RD_LAT) clocks; START is ignored while a run is active.
module ram_bist_ctrl
   import ram_bist_ctrl_pkg::*;
#(
   parameter int AW     = 4,
   parameter int DW     = 4,
   parameter int SEED   = 2,
   parameter int RD_LAT = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   output logic [AW-1:0]    A,
   output logic [DW-1:0]    D,
   output logic             EN,
   output logic             WR,
   input  logic [DW-1:0]    Q,
   output logic             BUSY,
   output logic             DONE,
   output logic             FAIL,
   output logic [AW-1:0]    FAIL_ADDR,
   output logic [ERR_W-1:0] ERR_CNT
);

   localparam int            CW   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [AW-1:0] LAST = '1;

   state_t        st, st_nxt;
   logic [AW-1:0] addr, addr_nxt;
   logic          pass, pass_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          clr;
   logic          en_nxt, wr_nxt;
   logic [AW-1:0] a_nxt;
   logic [DW-1:0] d_nxt;
   logic [DW-1:0] rd_exp;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         st   <= S_IDLE;
         addr <= '0;
         pass <= 1'b0;
         cnt  <= '0;
         A    <= '0;
         D    <= '0;
         EN   <= 1'b0;
         WR   <= 1'b0;
      end else begin
         st   <= st_nxt;
         addr <= addr_nxt;
         pass <= pass_nxt;
         cnt  <= cnt_nxt;
         A    <= a_nxt;
         D    <= d_nxt;
         EN   <= en_nxt;
         WR   <= wr_nxt;
      end
   end

   always_comb begin
      st_nxt   = st;
      addr_nxt = addr;
      pass_nxt = pass;
      cnt_nxt  = cnt;
      clr      = 1'b0;
      case (st)
         S_IDLE: begin
            if (START) begin
               st_nxt   = S_WRITE;
               addr_nxt = '0;
               pass_nxt = 1'b0;
               clr      = 1'b1;
            end
         end
         S_WRITE: begin
            addr_nxt = addr + 1'b1;
            if (addr == LAST)
               st_nxt = S_READ;
         end
         S_READ: begin
            addr_nxt = addr + 1'b1;
            if (addr == LAST) begin
               st_nxt  = S_DRAIN;
               cnt_nxt = '0;
            end
         end
         S_DRAIN: begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == CW'(RD_LAT - 1)) begin
               if (!pass) begin
                  pass_nxt = 1'b1;
                  st_nxt   = S_WRITE;
               end else begin
                  st_nxt = S_FIN;
               end
            end
         end
         S_FIN:   st_nxt = S_IDLE;
         default: st_nxt = S_IDLE;
      endcase

      // Outputs are loaded from the next state so the registered drive matches st each cycle.
      en_nxt = (st_nxt == S_WRITE) || (st_nxt == S_READ);
      wr_nxt = (st_nxt == S_WRITE);
      a_nxt  = en_nxt ? addr_nxt : A;
      d_nxt  = wr_nxt ? DW'(pattern(pass_nxt, 32'(addr_nxt), SEED, DW)) : D;
   end

   assign BUSY   = (st == S_WRITE) || (st == S_READ) || (st == S_DRAIN);
   assign DONE   = (st == S_FIN);
   assign rd_exp = DW'(pattern(pass, 32'(addr), SEED, DW));

   ram_bist_chk #(
      .AW     (AW),
      .DW     (DW),
      .RD_LAT (RD_LAT)
   ) u_chk (
      .clk       (CLK),
      .rst       (RST),
      .clr       (clr),
      .iss       (st == S_READ),
      .iss_addr  (addr),
      .iss_exp   (rd_exp),
      .q         (Q),
      .fail      (FAIL),
      .fail_addr (FAIL_ADDR),
      .err_cnt   (ERR_CNT)
   );

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl with a behavioural 16x4 single-port RAM that can inject read faults.
module tb_ram_bist_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] a, d, q;
   logic       en, wr, busy, done, fail;
   logic [3:0] fail_addr;
   logic [7:0] err_cnt;

   int checks = 0;
   int failures = 0;
   int fault_mode = 0;

   typedef struct packed {
      logic       f;
      logic [3:0] fa;
      logic [7:0] ec;
   } res_t;

   typedef struct packed {
      logic       w;
      logic [3:0] a;
      logic [3:0] d;
   } op_t;

   res_t exp_q[$];
   op_t  op_q[$];

   ram_bist_ctrl #(.AW(4), .DW(4), .SEED(2), .RD_LAT(1)) dut (
      .CLK       (clk),
      .RST       (rst),
      .START     (start),
      .A         (a),
      .D         (d),
      .EN        (en),
      .WR        (wr),
      .Q         (q),
      .BUSY      (busy),
      .DONE      (done),
      .FAIL      (fail),
      .FAIL_ADDR (fail_addr),
      .ERR_CNT   (err_cnt)
   );

   always #5 clk = ~clk;

   logic [3:0] mem [16];
   always @(posedge clk) begin
      if (en) begin
         if (wr)
            mem[a] <= d;
         else if (fault_mode == 1)
            q <= mem[a] & 4'hE;
         else if (fault_mode == 2 && a == 4'd9)
            q <= mem[a] ^ 4'h1;
         else
            q <= mem[a];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Called at the negedge right after the START pulse; samples that cycle first.
   task automatic run_wait(output int busy_n, output int done_n, output bit timeout);
      busy_n  = 0;
      done_n  = 0;
      timeout = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            timeout = 1'b0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      int bn, dn; bit to; res_t r;
      rst = 1'b1;
      start = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if ({en, wr, busy, done} !== 4'b0) begin failures++; $display("FAIL reset_ctl: got %b expected 0000", {en, wr, busy, done}); end
      checks++; if ({fail, fail_addr, err_cnt} !== 13'd0) begin failures++; $display("FAIL reset_res: got %0h expected 0", {fail, fail_addr, err_cnt}); end
      checks++; if ({a, d} !== 8'd0) begin failures++; $display("FAIL reset_ad: got %0h expected 0", {a, d}); end
      start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      exp_q.push_back('{f: 1'b0, fa: 4'd0, ec: 8'd0});
      pulse_start();
      run_wait(bn, dn, to);
      checks++; if (to) begin failures++; $display("FAIL reset_run_timeout: got no DONE expected DONE"); end
      checks++; if (bn != 66) begin failures++; $display("FAIL reset_run_busy: got %0d expected 66", bn); end
      if (exp_q.size() > 0) begin
         r = exp_q.pop_front();
         checks++; if (fail !== r.f || err_cnt !== r.ec) begin failures++; $display("FAIL reset_run_res: got fail=%b err=%0d expected fail=%b err=%0d", fail, err_cnt, r.f, r.ec); end
      end
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_run_done_len: got done=%b busy=%b expected 0 0", done, busy); end
   endtask

   task automatic test_pattern();
      op_t o;
      logic [3:0] pd;
      int seen;
      fault_mode = 0;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < 16; i++) begin
            pd = 4'(i + 2);
            if (p == 1) pd = ~pd;
            op_q.push_back('{w: 1'b1, a: 4'(i), d: pd});
         end
         for (int i = 0; i < 16; i++)
            op_q.push_back('{w: 1'b0, a: 4'(i), d: 4'd0});
      end
      pulse_start();
      seen = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         if (en) begin
            seen++;
            if (op_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL pattern_extra_op: got op at a=%0d expected none", a);
            end else begin
               o = op_q.pop_front();
               checks++; if (wr !== o.w || a !== o.a) begin failures++; $display("FAIL pattern_op: got wr=%b a=%0d expected wr=%b a=%0d", wr, a, o.w, o.a); end
               if (o.w) begin
                  checks++; if (d !== o.d) begin failures++; $display("FAIL pattern_data: got d=%0d at a=%0d expected %0d", d, a, o.d); end
               end
            end
         end
         @(negedge clk);
      end
      checks++; if (seen != 64) begin failures++; $display("FAIL pattern_count: got %0d expected 64", seen); end
      op_q.delete();
      checks++; if (fail !== 1'b0) begin failures++; $display("FAIL pattern_fail: got %b expected 0", fail); end
      @(negedge clk);
   endtask

   task automatic test_stuck_bit();
      int bn, dn; bit to; res_t r;
      fault_mode = 1;
      exp_q.push_back('{f: 1'b1, fa: 4'd1, ec: 8'd16});
      pulse_start();
      run_wait(bn, dn, to);
      checks++; if (to) begin failures++; $display("FAIL stuck_timeout: got no DONE expected DONE"); end
      if (exp_q.size() > 0) begin
         r = exp_q.pop_front();
         checks++; if ({fail, fail_addr, err_cnt} !== {r.f, r.fa, r.ec}) begin failures++; $display("FAIL stuck_res: got fail=%b addr=%0d err=%0d expected fail=%b addr=%0d err=%0d", fail, fail_addr, err_cnt, r.f, r.fa, r.ec); end
      end
      @(negedge clk);
      fault_mode = 0;
   endtask

   task automatic test_addr9();
      int bn, dn; bit to; res_t r;
      fault_mode = 2;
      for (int run = 0; run < 2; run++) begin
         exp_q.push_back('{f: 1'b1, fa: 4'd9, ec: 8'd2});
         pulse_start();
         if (run == 1) begin
            checks++; if (fail !== 1'b0 || err_cnt !== 8'd0) begin failures++; $display("FAIL addr9_clear: got fail=%b err=%0d expected 0 0", fail, err_cnt); end
         end
         run_wait(bn, dn, to);
         checks++; if (to) begin failures++; $display("FAIL addr9_timeout: got no DONE expected DONE"); end
         if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            checks++; if ({fail, fail_addr, err_cnt} !== {r.f, r.fa, r.ec}) begin failures++; $display("FAIL addr9_res: run %0d got fail=%b addr=%0d err=%0d expected fail=%b addr=%0d err=%0d", run, fail, fail_addr, err_cnt, r.f, r.fa, r.ec); end
         end
         @(negedge clk);
      end
      fault_mode = 0;
   endtask

   task automatic test_start_ignored();
      int c, bn, dn;
      pulse_start();
      c = 1; bn = 0; dn = 0;
      for (int i = 0; i < 200 && dn == 0; i++) begin
         if (busy) bn++;
         if (done) dn++;
         start = (c == 5 || c == 40);
         @(negedge clk);
         c++;
      end
      start = 1'b0;
      checks++; if (bn != 66) begin failures++; $display("FAIL ignore_busy: got %0d expected 66", bn); end
      for (int i = 0; i < 5; i++) begin
         if (done) dn++;
         @(negedge clk);
      end
      checks++; if (dn != 1) begin failures++; $display("FAIL ignore_done_cnt: got %0d expected 1", dn); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignore_idle: got busy=%b expected 0", busy); end
   endtask

   task automatic test_back_to_back();
      int bn, dn; bit to; res_t r;
      pulse_start();
      run_wait(bn, dn, to);
      start = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle: got busy=%b expected 0", busy); end
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept: got busy=%b expected 1", busy); end
      exp_q.push_back('{f: 1'b0, fa: 4'd0, ec: 8'd0});
      run_wait(bn, dn, to);
      checks++; if (to || bn != 66) begin failures++; $display("FAIL b2b_busy: got %0d timeout=%b expected 66", bn, to); end
      if (exp_q.size() > 0) begin
         r = exp_q.pop_front();
         checks++; if (fail !== r.f || err_cnt !== r.ec) begin failures++; $display("FAIL b2b_res: got fail=%b err=%0d expected fail=%b err=%0d", fail, err_cnt, r.f, r.ec); end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midrun();
      int bn, dn; bit to; res_t r;
      pulse_start();
      for (int c = 1; c < 20; c++) @(negedge clk);
      checks++; if (en !== 1'b1 || wr !== 1'b0) begin failures++; $display("FAIL midrun_read: got en=%b wr=%b expected 1 0", en, wr); end
      #2 rst = 1'b1;
      #1;
      checks++; if ({en, wr, busy} !== 3'b000) begin failures++; $display("FAIL midrun_async: got en/wr/busy=%b expected 000", {en, wr, busy}); end
      dn = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) dn++;
      end
      checks++; if (dn != 0) begin failures++; $display("FAIL midrun_nodone: got %0d expected 0", dn); end
      rst = 1'b0;
      @(negedge clk);
      exp_q.push_back('{f: 1'b0, fa: 4'd0, ec: 8'd0});
      pulse_start();
      run_wait(bn, dn, to);
      checks++; if (to || bn != 66) begin failures++; $display("FAIL midrun_rerun: got busy=%0d timeout=%b expected 66", bn, to); end
      if (exp_q.size() > 0) begin
         r = exp_q.pop_front();
         checks++; if (fail !== r.f || err_cnt !== r.ec) begin failures++; $display("FAIL midrun_res: got fail=%b err=%0d expected fail=%b err=%0d", fail, err_cnt, r.f, r.ec); end
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_pattern();
      test_stuck_bit();
      test_addr9();
      test_start_ignored();
      test_back_to_back();
      test_reset_midrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
